// File: rtl/program_memory_arbiter_pkg.sv
// Shared types, defaults and address helpers for the program memory arbiter.
// Helpers work on 64-bit zero-extended values so any DATA_WIDTH up to 64 can use them.
package prog_mem_arb_pkg;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_DATA  = 1'b1
  } state_t;

  localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
  localparam int          WAIT_W            = 4;

  // Legal means word aligned, at or above the text base, and inside the ROM.
  function automatic logic addr_legal(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] depth);
    logic [63:0] offset;
    offset = addr - base;
    return (addr[1:0] == 2'b00) && (addr >= base) && ((offset >> 2) < depth);
  endfunction

  function automatic logic [63:0] word_index(input logic [63:0] addr,
                                             input logic [63:0] base);
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/program_memory_arbiter_if.sv
// Requester/ROM bus of the program memory arbiter: two request ports plus the ROM read port.
interface program_memory_arbiter_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 32
);
  localparam int ADDR_W = $clog2(MEMORY_DEPTH);

  logic                  fetch_req_i;
  logic [DATA_WIDTH-1:0] fetch_addr_i;
  logic                  fetch_gnt_o;
  logic                  fetch_valid_o;
  logic [DATA_WIDTH-1:0] fetch_data_o;
  logic                  fetch_err_o;

  logic                  data_req_i;
  logic [DATA_WIDTH-1:0] data_addr_i;
  logic                  data_gnt_o;
  logic                  data_valid_o;
  logic [DATA_WIDTH-1:0] data_data_o;
  logic                  data_err_o;

  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_data_i;

  modport slave (
    input  fetch_req_i, fetch_addr_i, data_req_i, data_addr_i, mem_data_i,
    output fetch_gnt_o, fetch_valid_o, fetch_data_o, fetch_err_o,
    output data_gnt_o, data_valid_o, data_data_o, data_err_o, mem_addr_o
  );

  modport master (
    output fetch_req_i, fetch_addr_i, data_req_i, data_addr_i, mem_data_i,
    input  fetch_gnt_o, fetch_valid_o, fetch_data_o, fetch_err_o,
    input  data_gnt_o, data_valid_o, data_data_o, data_err_o, mem_addr_o
  );

endinterface

// File: rtl/program_memory_arbiter_xlate.sv
// Byte address to ROM word index translation with legality check.
// Illegal addresses translate to index 0 so the ROM is never driven out of range.
module pm_addr_xlate
  import prog_mem_arb_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = DATA_WIDTH'(TEXT_BASE_DEFAULT),
  localparam int                   ADDR_W       = $clog2(MEMORY_DEPTH)
) (
  input  logic [DATA_WIDTH-1:0] addr,
  output logic [ADDR_W-1:0]     index,
  output logic                  legal
);

  logic [63:0] addr_ext;
  logic [63:0] base_ext;

  assign addr_ext = 64'(addr);
  assign base_ext = 64'(TEXT_BASE);
  assign legal    = addr_legal(addr_ext, base_ext, 64'(MEMORY_DEPTH));
  assign index    = legal ? ADDR_W'(word_index(addr_ext, base_ext)) : '0;

endmodule

// File: rtl/program_memory_arbiter.sv
// Shares the single-read-port program ROM between instruction fetch and data loads.
// Fetch wins by default; a data request that loses MAX_WAIT times in a row gets priority.
module program_memory_arbiter
  import prog_mem_arb_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = DATA_WIDTH'(TEXT_BASE_DEFAULT),
  parameter int                    MAX_WAIT     = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  program_memory_arbiter_if.slave  bus
);

  localparam int                ADDR_W   = $clog2(MEMORY_DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(MAX_WAIT);

  state_t                  state_reg, state_next;
  logic [WAIT_W-1:0]       wait_cnt_reg, wait_cnt_next;
  logic                    fetch_gnt, data_gnt;

  logic [DATA_WIDTH-1:0]   sel_addr;
  logic [ADDR_W-1:0]       sel_index;
  logic                    sel_legal;
  logic [DATA_WIDTH-1:0]   resp_data;

  logic                    fetch_valid_reg, data_valid_reg;
  logic [DATA_WIDTH-1:0]   fetch_data_reg, data_data_reg;
  logic                    fetch_err_reg, data_err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_FETCH;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // The counter only survives cycles where data keeps requesting and keeps losing.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (!bus.data_req_i || data_gnt) begin
      wait_cnt_next = '0;
    end else if (wait_cnt_reg != WAIT_TOP) begin
      wait_cnt_next = wait_cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH: if (wait_cnt_next == WAIT_TOP) state_next = S_DATA;
      S_DATA:  if (data_gnt || !bus.data_req_i) state_next = S_FETCH;
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    fetch_gnt = 1'b0;
    data_gnt  = 1'b0;
    if (state_reg == S_DATA) begin
      if (bus.data_req_i)       data_gnt  = 1'b1;
      else if (bus.fetch_req_i) fetch_gnt = 1'b1;
    end else begin
      if (bus.fetch_req_i)      fetch_gnt = 1'b1;
      else if (bus.data_req_i)  data_gnt  = 1'b1;
    end
  end

  assign sel_addr = data_gnt ? bus.data_addr_i : bus.fetch_addr_i;

  pm_addr_xlate #(
    .DATA_WIDTH   (DATA_WIDTH),
    .MEMORY_DEPTH (MEMORY_DEPTH),
    .TEXT_BASE    (TEXT_BASE)
  ) u_xlate (
    .addr  (sel_addr),
    .index (sel_index),
    .legal (sel_legal)
  );

  assign bus.mem_addr_o = (fetch_gnt || data_gnt) ? sel_index : '0;
  assign resp_data      = sel_legal ? bus.mem_data_i : '0;

  // Data/err registers only load on their own port's grant, so they hold between responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_valid_reg <= 1'b0;
      data_valid_reg  <= 1'b0;
      fetch_data_reg  <= '0;
      data_data_reg   <= '0;
      fetch_err_reg   <= 1'b0;
      data_err_reg    <= 1'b0;
    end else begin
      fetch_valid_reg <= fetch_gnt;
      data_valid_reg  <= data_gnt;
      if (fetch_gnt) begin
        fetch_data_reg <= resp_data;
        fetch_err_reg  <= !sel_legal;
      end
      if (data_gnt) begin
        data_data_reg <= resp_data;
        data_err_reg  <= !sel_legal;
      end
    end
  end

  assign bus.fetch_gnt_o   = fetch_gnt;
  assign bus.data_gnt_o    = data_gnt;
  assign bus.fetch_valid_o = fetch_valid_reg;
  assign bus.data_valid_o  = data_valid_reg;
  assign bus.fetch_data_o  = fetch_data_reg;
  assign bus.data_data_o   = data_data_reg;
  assign bus.fetch_err_o   = fetch_err_reg;
  assign bus.data_err_o    = data_err_reg;

endmodule
